apb_arb_master: RTL and testbench

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/apb_arb_master.sv | 132 +++++++++++++
 tb/tb_apb_arb_master.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding and packed command layout.
// Command layout, LSB first: wdata, word address (top bit selects the slave), write flag.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  function automatic int cmd_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int cmd_slave_bit(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

  function automatic int cmd_write_bit(input int data_w, input int addr_w);
    return data_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin grant, one transfer in flight, timeout abort.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CMD_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [CMD_WIDTH-1:0]  req_cmd0,
  input  logic [CMD_WIDTH-1:0]  req_cmd1,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata0,
  input  logic [DATA_WIDTH-1:0] prdata1,
  input  logic                  pready0,
  input  logic                  pready1
);

  localparam int ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);
  localparam int SLV_BIT  = cmd_slave_bit(DATA_WIDTH, ADDR_WIDTH);
  localparam int WR_BIT   = cmd_write_bit(DATA_WIDTH, ADDR_WIDTH);
  localparam int CNT_W    = $clog2(TIMEOUT + 1);

  apb_state_e            state_q;
  logic                  last_q;
  logic                  slv_q;
  logic [1:0]            psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  rsp_valid_q;
  logic                  rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic [1:0]            gnt;
  logic [CMD_WIDTH-1:0]  cmd_d;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;

  rr_arb2 u_arb (
    .req_i  (req_valid),
    .en_i   (state_q == ST_IDLE),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign req_ready = gnt;
  assign cmd_d     = gnt[1] ? req_cmd1 : req_cmd0;
  assign sel_ready = slv_q ? pready1 : pready0;
  assign sel_rdata = slv_q ? prdata1 : prdata0;
  assign cnt_d     = cnt_q + CNT_W'(1);

  // last_q doubles as the id of the transfer in flight, since it only moves on a grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      slv_q       <= 1'b0;
      psel_q      <= 2'b00;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            state_q  <= ST_SETUP;
            last_q   <= gnt[1];
            slv_q    <= cmd_d[SLV_BIT];
            psel_q   <= cmd_d[SLV_BIT] ? 2'b10 : 2'b01;
            pwrite_q <= cmd_d[WR_BIT];
            paddr_q  <= cmd_d[ADDR_LSB +: ADDR_WIDTH];
            pwdata_q <= cmd_d[DATA_WIDTH-1:0];
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (!sel_ready) cnt_q <= cnt_d;
          // A ready on the final wait cycle still counts as a normal completion.
          if (sel_ready || cnt_d == CNT_W'(TIMEOUT)) begin
            state_q     <= ST_IDLE;
            psel_q      <= 2'b00;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= last_q;
            rsp_err_q   <= !sel_ready;
            rsp_rdata_q <= (sel_ready && !pwrite_q) ? sel_rdata : '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: directed scenarios plus a randomized run against a transaction timeline model.
module tb_apb_arb_master;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int CW = DW + AW + 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [CW-1:0] req_cmd0 = '0;
  logic [CW-1:0] req_cmd1 = '0;
  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [1:0]    psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata0 = '0;
  logic [DW-1:0] prdata1 = '0;
  logic          pready0 = 1'b0;
  logic          pready1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_arb_master #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CMD_WIDTH  (CW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd0  (req_cmd0),
    .req_cmd1  (req_cmd1),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata0   (prdata0),
    .prdata1   (prdata1),
    .pready0   (pready0),
    .pready1   (pready1)
  );

  function automatic logic [CW-1:0] mk_cmd(input logic wr, input logic [AW:0] a, input logic [DW-1:0] d);
    return {wr, a, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    smp();
    checks++;
    if ({psel, penable, pwrite} !== 4'b0000) begin
      errors++; $display("FAIL reset_apb_ctrl: got %b expected 0000", {psel, penable, pwrite});
    end
    checks++;
    if ({paddr, pwdata} !== '0) begin
      errors++; $display("FAIL reset_apb_data: got %h/%h expected 0/0", paddr, pwdata);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_rsp: got v%b id%b e%b d%h expected all 0", rsp_valid, rsp_id, rsp_err, rsp_rdata);
    end
    step();
    rstn = 1'b1;
  endtask

  task automatic test_zero_wait_write();
    step();
    req_valid = 2'b01;
    req_cmd0  = mk_cmd(1'b1, 13'h005, 32'hA5A5A5A5);
    pready0   = 1'b1;
    smp();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL zw_grant: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    smp();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {2'b01, 1'b0, 1'b1, 12'h005, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL zw_setup: got psel%b en%b wr%b a%h d%h expected psel01 en0 wr1 a005 dA5A5A5A5",
                         psel, penable, pwrite, paddr, pwdata);
    end
    step();
    smp();
    checks++;
    if ({psel, penable, rsp_valid} !== 4'b0110) begin
      errors++; $display("FAIL zw_access: got psel%b en%b rv%b expected psel01 en1 rv0", psel, penable, rsp_valid);
    end
    step();
    smp();
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_rdata, psel} !== {3'b100, 32'h0, 2'b00}) begin
      errors++; $display("FAIL zw_rsp: got v%b id%b e%b d%h psel%b expected v1 id0 e0 d0 psel00",
                         rsp_valid, rsp_id, rsp_err, rsp_rdata, psel);
    end
    step();
    pready0 = 1'b0;
    smp();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL zw_rsp_pulse: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    step();
    req_valid = 2'b10;
    req_cmd1  = mk_cmd(1'b0, 13'h1010, 32'hDEADBEEF);
    prdata0   = 32'hFFFFFFFF;
    prdata1   = 32'h12345678;
    pready0   = 1'b1;
    pready1   = 1'b0;
    smp();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL rd_grant: got %b expected 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    smp();
    checks++;
    if ({psel, penable, pwrite, paddr} !== {2'b10, 1'b0, 1'b0, 12'h010}) begin
      errors++; $display("FAIL rd_setup: got psel%b en%b wr%b a%h expected psel10 en0 wr0 a010", psel, penable, pwrite, paddr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) pready1 = 1'b1;
      smp();
      checks++;
      if ({psel, penable, rsp_valid} !== 4'b1010) begin
        errors++; $display("FAIL rd_access%0d: got psel%b en%b rv%b expected psel10 en1 rv0", i, psel, penable, rsp_valid);
      end
    end
    step();
    pready1 = 1'b0;
    pready0 = 1'b0;
    smp();
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_rdata, psel} !== {3'b110, 32'h12345678, 2'b00}) begin
      errors++; $display("FAIL rd_rsp: got v%b id%b e%b d%h psel%b expected v1 id1 e0 d12345678 psel00",
                         rsp_valid, rsp_id, rsp_err, rsp_rdata, psel);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int m = 0;
    step();
    req_valid = 2'b11;
    req_cmd0  = mk_cmd(1'b1, 13'h0001, 32'h1);
    req_cmd1  = mk_cmd(1'b1, 13'h1002, 32'h2);
    pready0   = 1'b1;
    pready1   = 1'b1;
    for (int c = 0; c < 60 && (n < 4 || m < 4); c++) begin
      smp();
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_id !== m[0]) begin
          errors++; $display("FAIL rr_rsp_id%0d: got %b expected %b", m, rsp_id, m[0]);
        end
        m++;
      end
      if (req_ready !== 2'b00) begin
        checks++;
        if (req_ready !== (n[0] ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, (n[0] ? 2'b10 : 2'b01));
        end
        n++;
      end
      step();
      if (n >= 4) req_valid = 2'b00;
    end
    checks++;
    if (n != 4 || m != 4) begin
      errors++; $display("FAIL rr_count: got grants %0d rsps %0d expected 4/4", n, m);
    end
    req_valid = 2'b00;
    pready0   = 1'b0;
    pready1   = 1'b0;
  endtask

  task automatic test_timeout();
    int acc = 0;
    step();
    req_valid = 2'b01;
    req_cmd0  = mk_cmd(1'b0, 13'h00AB, 32'h0);
    prdata0   = 32'h87654321;
    pready0   = 1'b0;
    pready1   = 1'b1;
    smp();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL to_grant: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    smp();
    for (int c = 0; c < 40; c++) begin
      step();
      smp();
      if (psel === 2'b01 && penable === 1'b1) acc++;
      else break;
    end
    checks++;
    if (acc != TO) begin
      errors++; $display("FAIL to_access_len: got %0d expected %0d", acc, TO);
    end
    checks++;
    if ({psel, penable, rsp_valid, rsp_id, rsp_err, rsp_rdata} !== {2'b00, 1'b0, 3'b101, 32'h0}) begin
      errors++; $display("FAIL to_rsp: got psel%b en%b v%b id%b e%b d%h expected psel00 en0 v1 id0 e1 d0",
                         psel, penable, rsp_valid, rsp_id, rsp_err, rsp_rdata);
    end
    step();
    req_valid = 2'b10;
    req_cmd1  = mk_cmd(1'b0, 13'h1FFF, 32'h0);
    prdata1   = 32'hCAFEF00D;
    smp();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL to_next_grant: got %b expected 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    repeat (2) step();
    smp();
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_rdata} !== {3'b110, 32'hCAFEF00D}) begin
      errors++; $display("FAIL to_next_rsp: got v%b id%b e%b d%h expected v1 id1 e0 dCAFEF00D",
                         rsp_valid, rsp_id, rsp_err, rsp_rdata);
    end
    pready1 = 1'b0;
  endtask

  task automatic test_timeout_boundary();
    step();
    req_valid = 2'b01;
    req_cmd0  = mk_cmd(1'b0, 13'h007E, 32'h0);
    prdata0   = 32'h55AA55AA;
    step();
    req_valid = 2'b00;
    for (int a = 1; a <= TO; a++) begin
      step();
      if (a == TO) pready0 = 1'b1;
      smp();
      checks++;
      if ({psel, penable} !== 3'b011) begin
        errors++; $display("FAIL tb_access%0d: got psel%b en%b expected psel01 en1", a, psel, penable);
      end
    end
    step();
    pready0 = 1'b0;
    smp();
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_rdata} !== {3'b100, 32'h55AA55AA}) begin
      errors++; $display("FAIL tb_rsp: got v%b id%b e%b d%h expected v1 id0 e0 d55AA55AA",
                         rsp_valid, rsp_id, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    step();
    req_valid = 2'b01;
    req_cmd0  = mk_cmd(1'b1, 13'h1003, 32'h33);
    step();
    req_valid = 2'b00;
    step();
    smp();
    checks++;
    if ({psel, penable} !== 3'b101) begin
      errors++; $display("FAIL rst_pre_access: got psel%b en%b expected psel10 en1", psel, penable);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({psel, penable} !== 3'b000) begin
      errors++; $display("FAIL rst_async: got psel%b en%b expected 000", psel, penable);
    end
    step();
    smp();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_no_rsp: got %b expected 0", rsp_valid);
    end
    step();
    rstn      = 1'b1;
    req_valid = 2'b11;
    req_cmd0  = mk_cmd(1'b1, 13'h0004, 32'h44);
    req_cmd1  = mk_cmd(1'b1, 13'h1005, 32'h55);
    pready0   = 1'b1;
    smp();
    checks++;
    if ({req_ready, rsp_valid} !== 3'b010) begin
      errors++; $display("FAIL rst_ptr: got gnt%b rv%b expected gnt01 rv0", req_ready, rsp_valid);
    end
    step();
    req_valid = 2'b00;
    smp();
    checks++;
    if ({psel, paddr, pwdata} !== {2'b01, 12'h004, 32'h44}) begin
      errors++; $display("FAIL rst_after_setup: got psel%b a%h d%h expected psel01 a004 d44", psel, paddr, pwdata);
    end
    repeat (2) step();
    smp();
    checks++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b100) begin
      errors++; $display("FAIL rst_after_rsp: got v%b id%b e%b expected v1 id0 e0", rsp_valid, rsp_id, rsp_err);
    end
    pready0 = 1'b0;
    repeat (3) step();
    smp();
    checks++;
    if ({psel, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_no_replay: got psel%b rv%b expected 000", psel, rsp_valid);
    end
  endtask

  // Timeline model: after a grant, next cycle is SETUP, then ACCESS until the
  // selected ready or TO waits; the response appears the cycle after.
  task automatic test_random();
    bit            busy = 1'b0;
    bit            rsp_pend = 1'b0;
    bit            last = 1'b1;
    int            k = 0;
    logic          m_wr, m_slv, m_id, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    logic [1:0]    g;
    logic [CW-1:0] c;
    logic          sel_rdy;
    m_wr = 1'b0; m_slv = 1'b0; m_id = 1'b0; m_err = 1'b0;
    m_addr = '0; m_wd = '0; m_rd = '0;
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      req_valid = 2'($urandom_range(0, 3));
      req_cmd0  = mk_cmd(1'($urandom), 13'($urandom), $urandom);
      req_cmd1  = mk_cmd(1'($urandom), 13'($urandom), $urandom);
      pready0   = ($urandom_range(0, 2) == 0);
      pready1   = ($urandom_range(0, 2) == 0);
      prdata0   = $urandom;
      prdata1   = $urandom;
      smp();
      checks++;
      if (rsp_valid !== rsp_pend) begin
        errors++; $display("FAIL rnd_rsp_valid@%0d: got %b expected %b", cyc, rsp_valid, rsp_pend);
      end
      if (rsp_pend) begin
        checks++;
        if ({rsp_id, rsp_err, rsp_rdata} !== {m_id, m_err, m_rd}) begin
          errors++; $display("FAIL rnd_rsp@%0d: got id%b e%b d%h expected id%b e%b d%h",
                             cyc, rsp_id, rsp_err, rsp_rdata, m_id, m_err, m_rd);
        end
        rsp_pend = 1'b0;
      end
      if (busy) begin
        k++;
        checks++;
        if ({req_ready, psel, penable, pwrite, paddr, pwdata} !==
            {2'b00, (m_slv ? 2'b10 : 2'b01), (k >= 2), m_wr, m_addr, m_wd}) begin
          errors++; $display("FAIL rnd_apb@%0d: got rr%b psel%b en%b wr%b a%h d%h expected rr00 slv%b en%b wr%b a%h d%h",
                             cyc, req_ready, psel, penable, pwrite, paddr, pwdata, m_slv, (k >= 2), m_wr, m_addr, m_wd);
        end
        if (k >= 2) begin
          sel_rdy = m_slv ? pready1 : pready0;
          if (sel_rdy) begin
            rsp_pend = 1'b1; m_err = 1'b0; busy = 1'b0;
            m_rd = m_wr ? '0 : (m_slv ? prdata1 : prdata0);
          end else if (k - 1 == TO) begin
            rsp_pend = 1'b1; m_err = 1'b1; busy = 1'b0; m_rd = '0;
          end
        end
      end else begin
        if (req_valid == 2'b11) g = last ? 2'b01 : 2'b10;
        else                    g = req_valid;
        checks++;
        if ({req_ready, psel, penable} !== {g, 3'b000}) begin
          errors++; $display("FAIL rnd_idle@%0d: got rr%b psel%b en%b expected rr%b psel00 en0",
                             cyc, req_ready, psel, penable, g);
        end
        if (g != 2'b00) begin
          m_id = g[1];
          last = g[1];
          c = g[1] ? req_cmd1 : req_cmd0;
          {m_wr, m_slv, m_addr, m_wd} = c;
          busy = 1'b1;
          k = 0;
        end
      end
    end
    req_valid = 2'b00;
    pready0   = 1'b0;
    pready1   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_round_robin();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
